stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control and timekeeping sequencer for the stopwatch. It consumes the free-running divided clocks from the clock divider as plain level signals, synchronizes and edge-detects them into single-cycle enables, and schedules them. 1 Hz drives counting, 2 Hz drives adjust, the fast clock drives button debounce and the blink clock drives digit blanking. It owns the run/pause/adjust state machine and the MM:SS BCD time registers that feed the display driver.

## Interface
- No parameters; divider rates are fixed by the clock divider (count 1 Hz, adj 2 Hz, fast ~100 Hz, blink ~1.5 Hz at 100 MHz clk).
- clk  in  1  system clock, 100 MHz, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- count_clk  in  1  1 Hz square wave from divider
- adj_clk  in  1  2 Hz square wave from divider
- fast_clk  in  1  debounce sample square wave from divider
- blink_clk  in  1  blink square wave from divider
- btn_pause  in  1  raw pause button, active-high, asynchronous
- btn_rst  in  1  raw clear button, active-high, asynchronous
- sw_adj  in  1  adjust-mode switch, asynchronous
- sw_sel  in  1  adjust field select: 0 = minutes, 1 = seconds, asynchronous
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time digits
- blank  out  4  per-digit blank {min_tens, min_ones, sec_tens, sec_ones}, 1 = dark
- paused  out  1  1 when in PAUSE state

## Operation
- All eight inputs pass through 2-FF synchronizers. A third register on each divider clock gives a rising-edge tick = sync2 & ~sync3: count_tick, adj_tick, fast_tick. blink uses the sync2 level only.
- Debounce per button: sample the sync2 level on each fast_tick. The debounced level changes only after 3 consecutive equal samples. A press event is a 0->1 transition of the debounced level and lasts exactly one clk cycle.
- States: RUN, PAUSE, ADJ. Reset state is RUN.
  - RUN: on pause press, go to PAUSE. On sw_adj=1, go to ADJ and remember RUN.
  - PAUSE: on pause press, go to RUN. On sw_adj=1, go to ADJ and remember PAUSE.
  - ADJ: on sw_adj=0, return to the remembered state. Pause presses are ignored.
- Counting in RUN, on count_tick: sec_ones increments. 9 wraps to 0 with carry to sec_tens. 5 wraps to 0 with carry to min_ones, then min_tens. 59:59 wraps to 00:00.
- Adjust in ADJ, on adj_tick: increment only the selected two-digit field, 00..59, wrapping 59->00. There is no carry between fields. count_tick is ignored in ADJ.
- Clear press: time becomes 00:00 in any state. State and the remembered state are unchanged.
- Blank: all 0 outside ADJ. In ADJ, the selected pair is blanked while blink sync2 = 1 (minutes -> 4'b1100, seconds -> 4'b0011).
- Simultaneous events: clear press beats count_tick or adj_tick in the same cycle. A pause press and a count_tick in the same cycle in RUN both take effect: the time increments and the state becomes PAUSE.
- BCD digits never hold a value above 9, and tens digits never hold a value above 5.

## Timing
- Reset (rst_n=0, async): all digits 0, blank=0000, paused=0, state RUN, remembered state RUN, synchronizers, edge registers and debounce counters 0, debounced levels 0.
- Divider edge latency: an input first high at clk edge 1 gives time updated at edge 3. This is exactly one update per divider period.
- Button latency: the debounced level rises on the 3rd consecutive high fast_tick sample. The state or time change lands on the next clk edge.
- sw_adj/sw_sel: the state or field change takes effect 3 clk edges after the switch is sampled, with no debounce.
- All outputs are registered, including blank and paused. There are no combinational input-to-output paths.
- Reset deasserted mid-count resumes from 00:00 in RUN.

## Test plan
- Reset, then 60 count_clk periods in RUN -> 01:00, paused=0, blank=0000; divider input high -> digits change on the 3rd clk edge.
- Preload 59:58 via ADJ, exit to RUN, 2 count ticks -> 59:59 then 00:00.
- Pause pulse held across 3 fast samples -> paused=1 and count ticks ignored; a 2-sample glitch -> no change.
- ADJ with sw_sel=1 at 00:59, 1 adj tick -> 00:00 (minutes unchanged). With blink high -> blank=0011. With sw_sel=0 -> blank=1100.
- Enter ADJ from PAUSE, press pause (ignored), leave ADJ -> back in PAUSE, paused=1.
- Clear press coincident with count_tick at 12:34 -> 00:00. rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer and MM:SS BCD timekeeping for the stopwatch
// Ports:
//   clk, rst_n                                   system clock, async active-low reset
//   count_clk, adj_clk, fast_clk, blink_clk      divider square waves (1 Hz, 2 Hz, debounce, blink)
//   btn_pause, btn_rst                           raw buttons, active-high
//   sw_adj, sw_sel                               adjust enable, field select (0 = minutes, 1 = seconds)
//   min_tens, min_ones, sec_tens, sec_ones       BCD time digits
//   blank                                        per-digit blank {mt, mo, st, so}, 1 = dark
//   paused                                       1 while in PAUSE
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_clk,
  input  logic       adj_clk,
  input  logic       fast_clk,
  input  logic       blink_clk,
  input  logic       btn_pause,
  input  logic       btn_rst,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic       paused
);
  typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;
  state_t state, nstate, ret, nret;
  logic [7:0] s1, s2;
  logic [2:0] s3;
  logic [1:0] db, db_d;
  logic [1:0] cnt [2];
  logic [7:0] sec, mins, nsec, nmin;
  logic count_tick, adj_tick, fast_tick, blink, adj_on, sel, pause_press, clr_press;
  // bit order: 0 count, 1 adj, 2 fast, 3 blink, 4 pause, 5 clear, 6 sw_adj, 7 sw_sel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {sw_sel, sw_adj, btn_rst, btn_pause, blink_clk, fast_clk, adj_clk, count_clk};
      s2 <= s1;
      s3 <= s2[2:0];
    end
  assign count_tick  = s2[0] & ~s3[0];
  assign adj_tick    = s2[1] & ~s3[1];
  assign fast_tick   = s2[2] & ~s3[2];
  assign blink       = s2[3];
  assign adj_on      = s2[6];
  assign sel         = s2[7];
  assign pause_press = db[0] & ~db_d[0];
  assign clr_press   = db[1] & ~db_d[1];
  // a differing sample must repeat on three consecutive fast ticks before the level flips
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db   <= '0;
      db_d <= '0;
      cnt  <= '{default: 2'd0};
    end else begin
      db_d <= db;
      for (int i = 0; i < 2; i++)
        if (fast_tick) begin
          if (s2[4+i] == db[i]) cnt[i] <= 2'd0;
          else if (cnt[i] == 2'd2) begin
            db[i]  <= s2[4+i];
            cnt[i] <= 2'd0;
          end else cnt[i] <= cnt[i] + 2'd1;
        end
    end
  function automatic logic [7:0] inc59(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {(v[7:4] == 4'd5 ? 4'd0 : v[7:4] + 4'd1), 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  always_comb begin
    nstate = state;
    nret   = ret;
    case (state)
      RUN:     if (adj_on) begin nstate = ADJ; nret = RUN; end
               else if (pause_press) nstate = PAUSE;
      PAUSE:   if (adj_on) begin nstate = ADJ; nret = PAUSE; end
               else if (pause_press) nstate = RUN;
      default: if (!adj_on) nstate = ret;
    endcase
  end
  // clear wins over any tick; a RUN-state tick still counts in the cycle a pause press lands
  always_comb begin
    nsec = sec;
    nmin = mins;
    if (clr_press) begin
      nsec = 8'h00;
      nmin = 8'h00;
    end else if (state == RUN && count_tick) begin
      nsec = inc59(sec);
      nmin = sec == 8'h59 ? inc59(mins) : mins;
    end else if (state == ADJ && adj_tick) begin
      nsec = sel ? inc59(sec) : sec;
      nmin = sel ? mins : inc59(mins);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= RUN;
      ret    <= RUN;
      sec    <= 8'h00;
      mins   <= 8'h00;
      blank  <= 4'b0000;
      paused <= 1'b0;
    end else begin
      state  <= nstate;
      ret    <= nret;
      sec    <= nsec;
      mins   <= nmin;
      blank  <= (nstate == ADJ && blink) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
      paused <= nstate == PAUSE;
    end
  assign {min_tens, min_ones} = mins;
  assign {sec_tens, sec_ones} = sec;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic count_clk = 1'b0, adj_clk = 1'b0, fast_clk = 1'b0, blink_clk = 1'b0;
  logic btn_pause = 1'b0, btn_rst = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic paused;
  logic [15:0] t;
  int tests = 0, fails = 0;
  stopwatch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .count_clk(count_clk), .adj_clk(adj_clk), .fast_clk(fast_clk),
    .blink_clk(blink_clk), .btn_pause(btn_pause), .btn_rst(btn_rst), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blank(blank), .paused(paused)
  );
  always #5 clk = ~clk;
  assign t = {min_tens, min_ones, sec_tens, sec_ones};
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_count();
    @(negedge clk) count_clk = 1'b1;
    wait_cyc(3);
    count_clk = 1'b0;
    wait_cyc(3);
  endtask
  task automatic pulse_adj();
    @(negedge clk) adj_clk = 1'b1;
    wait_cyc(3);
    adj_clk = 1'b0;
    wait_cyc(3);
  endtask
  task automatic pulse_fast();
    @(negedge clk) fast_clk = 1'b1;
    wait_cyc(3);
    fast_clk = 1'b0;
    wait_cyc(3);
  endtask
  task automatic press_pause();
    btn_pause = 1'b1;
    repeat (3) pulse_fast();
    btn_pause = 1'b0;
    repeat (3) pulse_fast();
  endtask
  task automatic test_reset();
    wait_cyc(2);
    tests++; if (t !== 16'h0000) begin fails++; $display("FAIL reset_time got=%h exp=%h", t, 16'h0000); end
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL reset_blank got=%b exp=%b", blank, 4'b0000); end
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL reset_paused got=%b exp=0", paused); end
    @(negedge clk) rst_n = 1'b1;
    wait_cyc(2);
  endtask
  task automatic test_count_latency();
    @(negedge clk) count_clk = 1'b1;
    @(negedge clk);
    tests++; if (t !== 16'h0000) begin fails++; $display("FAIL lat_edge1 got=%h exp=%h", t, 16'h0000); end
    @(negedge clk);
    tests++; if (t !== 16'h0000) begin fails++; $display("FAIL lat_edge2 got=%h exp=%h", t, 16'h0000); end
    @(negedge clk);
    tests++; if (t !== 16'h0001) begin fails++; $display("FAIL lat_edge3 got=%h exp=%h", t, 16'h0001); end
    count_clk = 1'b0;
    wait_cyc(3);
    tests++; if (t !== 16'h0001) begin fails++; $display("FAIL lat_single got=%h exp=%h", t, 16'h0001); end
  endtask
  task automatic test_count_60();
    repeat (59) pulse_count();
    tests++; if (t !== 16'h0100) begin fails++; $display("FAIL count60 got=%h exp=%h", t, 16'h0100); end
    tests++; if (paused !== 1'b0 || blank !== 4'b0000) begin fails++; $display("FAIL count60_flags got=%b/%b exp=0/0000", paused, blank); end
  endtask
  task automatic test_wrap();
    sw_adj = 1'b1; sw_sel = 1'b0;
    wait_cyc(4);
    repeat (58) pulse_adj();
    sw_sel = 1'b1;
    wait_cyc(4);
    repeat (58) pulse_adj();
    tests++; if (t !== 16'h5958) begin fails++; $display("FAIL preload got=%h exp=%h", t, 16'h5958); end
    sw_adj = 1'b0;
    wait_cyc(4);
    pulse_count();
    tests++; if (t !== 16'h5959) begin fails++; $display("FAIL wrap_5959 got=%h exp=%h", t, 16'h5959); end
    pulse_count();
    tests++; if (t !== 16'h0000) begin fails++; $display("FAIL wrap_0000 got=%h exp=%h", t, 16'h0000); end
  endtask
  task automatic test_pause();
    press_pause();
    tests++; if (paused !== 1'b1) begin fails++; $display("FAIL pause_on got=%b exp=1", paused); end
    pulse_count();
    tests++; if (t !== 16'h0000) begin fails++; $display("FAIL pause_hold got=%h exp=%h", t, 16'h0000); end
    btn_pause = 1'b1;
    repeat (2) pulse_fast();
    btn_pause = 1'b0;
    repeat (2) pulse_fast();
    tests++; if (paused !== 1'b1) begin fails++; $display("FAIL glitch got=%b exp=1", paused); end
    press_pause();
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL pause_off got=%b exp=0", paused); end
    pulse_count();
    tests++; if (t !== 16'h0001) begin fails++; $display("FAIL resume got=%h exp=%h", t, 16'h0001); end
  endtask
  task automatic test_adj();
    sw_adj = 1'b1; sw_sel = 1'b0;
    wait_cyc(4);
    repeat (3) pulse_adj();
    sw_sel = 1'b1;
    wait_cyc(4);
    repeat (58) pulse_adj();
    tests++; if (t !== 16'h0359) begin fails++; $display("FAIL adj_0359 got=%h exp=%h", t, 16'h0359); end
    pulse_adj();
    tests++; if (t !== 16'h0300) begin fails++; $display("FAIL adj_nocarry got=%h exp=%h", t, 16'h0300); end
    pulse_count();
    tests++; if (t !== 16'h0300) begin fails++; $display("FAIL adj_nocount got=%h exp=%h", t, 16'h0300); end
    blink_clk = 1'b1;
    wait_cyc(4);
    tests++; if (blank !== 4'b0011) begin fails++; $display("FAIL blank_sec got=%b exp=%b", blank, 4'b0011); end
    sw_sel = 1'b0;
    wait_cyc(4);
    tests++; if (blank !== 4'b1100) begin fails++; $display("FAIL blank_min got=%b exp=%b", blank, 4'b1100); end
    blink_clk = 1'b0;
    wait_cyc(4);
    tests++; if (blank !== 4'b0000) begin fails++; $display("FAIL blank_off got=%b exp=%b", blank, 4'b0000); end
  endtask
  task automatic test_adj_from_pause();
    sw_adj = 1'b0;
    wait_cyc(4);
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL ret_run got=%b exp=0", paused); end
    press_pause();
    tests++; if (paused !== 1'b1) begin fails++; $display("FAIL pause2 got=%b exp=1", paused); end
    sw_adj = 1'b1;
    wait_cyc(4);
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL adj_paused got=%b exp=0", paused); end
    press_pause();
    sw_adj = 1'b0;
    wait_cyc(4);
    tests++; if (paused !== 1'b1) begin fails++; $display("FAIL ret_pause got=%b exp=1", paused); end
    pulse_count();
    tests++; if (t !== 16'h0300) begin fails++; $display("FAIL ret_pause_hold got=%h exp=%h", t, 16'h0300); end
    press_pause();
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL pause3_off got=%b exp=0", paused); end
  endtask
  task automatic test_clear();
    sw_adj = 1'b1; sw_sel = 1'b0;
    wait_cyc(4);
    repeat (9) pulse_adj();
    sw_sel = 1'b1;
    wait_cyc(4);
    repeat (34) pulse_adj();
    sw_adj = 1'b0;
    wait_cyc(4);
    tests++; if (t !== 16'h1234) begin fails++; $display("FAIL preload_1234 got=%h exp=%h", t, 16'h1234); end
    btn_rst = 1'b1;
    repeat (2) pulse_fast();
    @(negedge clk) fast_clk = 1'b1;
    @(negedge clk) count_clk = 1'b1;
    wait_cyc(4);
    fast_clk = 1'b0; count_clk = 1'b0;
    wait_cyc(3);
    tests++; if (t !== 16'h0000) begin fails++; $display("FAIL clear_wins got=%h exp=%h", t, 16'h0000); end
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL clear_state got=%b exp=0", paused); end
    btn_rst = 1'b0;
    repeat (3) pulse_fast();
    pulse_count();
    tests++; if (t !== 16'h0001) begin fails++; $display("FAIL after_clear got=%h exp=%h", t, 16'h0001); end
  endtask
  task automatic test_async_reset();
    pulse_count();
    sw_adj = 1'b1; sw_sel = 1'b0; blink_clk = 1'b1;
    wait_cyc(4);
    tests++; if (blank !== 4'b1100 || t !== 16'h0002) begin fails++; $display("FAIL pre_reset got=%b/%h exp=1100/0002", blank, t); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (t !== 16'h0000 || blank !== 4'b0000 || paused !== 1'b0) begin fails++; $display("FAIL async_reset got=%h/%b/%b exp=0000/0000/0", t, blank, paused); end
    sw_adj = 1'b0; blink_clk = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    pulse_count();
    tests++; if (t !== 16'h0001 || paused !== 1'b0) begin fails++; $display("FAIL post_reset got=%h/%b exp=0001/0", t, paused); end
  endtask
  initial begin
    test_reset();
    test_count_latency();
    test_count_60();
    test_wrap();
    test_pause();
    test_adj();
    test_adj_from_pause();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
